// File: rtl/nou_axi_pkg.sv
// ============================================================================
// nou_axi_pkg : shared issue-stage states and AXI helpers       rev 1.0
// ============================================================================
`default_nettype none

package nou_axi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nou_out_credit.sv
// ============================================================================
// nou_out_credit : outstanding-transaction up/down counter      rev 1.0
// ============================================================================
`default_nettype none

module nou_out_credit #(
    parameter int MAX_OUT = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic dec,
    output logic slot_avail
);

    localparam logic [7:0] C_MAX = 8'(MAX_OUT);

    logic [7:0] r_cnt;

    // Simultaneous inc/dec cancel; a stray dec at zero is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (inc && !dec && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end else if (dec && !inc && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign slot_avail = (r_cnt < C_MAX);

endmodule

`default_nettype wire

// File: rtl/axi_aw_w_master_ctl.sv
// ============================================================================
// axi_aw_w_master_ctl : one single-beat AXI write per flit of a packet  rev 1.0
// ============================================================================
`default_nettype none

module axi_aw_w_master_ctl
    import nou_axi_pkg::*;
#(
    parameter int ADDR_W    = 40,
    parameter int DATA_W    = 128,
    parameter int HDR_NUM_W = 8,
    parameter int DAT_NUM_W = 16,
    parameter int MAX_OUT   = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [HDR_NUM_W-1:0]  hdr_num_in,
    input  logic [DAT_NUM_W-1:0]  dat_num_in,
    output logic                  busy,
    output logic                  issue_done,
    output logic                  issue_abort,
    output logic [HDR_NUM_W-1:0]  header_flit_num,
    output logic [DAT_NUM_W-1:0]  data_flit_num,
    input  logic                  flit_vld,
    input  logic [DATA_W-1:0]     flit_data,
    output logic                  flit_rdy,
    input  logic                  b_hsk,
    input  logic                  wr_err,
    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic [7:0]            axi_awlen,
    output logic [2:0]            axi_awsize,
    output logic [1:0]            axi_awburst,
    output logic                  axi_awvld,
    input  logic                  axi_awrdy,
    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,
    output logic                  axi_wlast,
    output logic                  axi_wvld,
    input  logic                  axi_wrdy
);

    localparam int TOT_W  = ((HDR_NUM_W > DAT_NUM_W) ? HDR_NUM_W : DAT_NUM_W) + 1;
    localparam int C_SIZE = clog2(DATA_W / 8);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [TOT_W-1:0]   r_total;
    logic [TOT_W-1:0]   r_index;
    logic               r_err;

    logic               w_slot;
    logic               w_accept;
    logic               w_aw_pend;
    logic               w_w_pend;
    logic [ADDR_W-1:0]  w_offset;

    assign axi_awlen   = 8'd0;
    assign axi_awsize  = 3'(C_SIZE);
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_wstrb   = '1;
    assign axi_wlast   = 1'b1;

    assign flit_rdy = (r_state == ISSUE) && (r_index < r_total) && w_slot
                    && (!axi_awvld || axi_awrdy) && (!axi_wvld || axi_wrdy)
                    && !wr_err && !r_err;
    assign w_accept = flit_vld && flit_rdy;

    // Whether each channel still holds a beat after this cycle's handshakes.
    assign w_aw_pend = w_accept || (axi_awvld && !axi_awrdy);
    assign w_w_pend  = w_accept || (axi_wvld && !axi_wrdy);
    assign w_offset  = ADDR_W'(r_index) << C_SIZE;

    nou_out_credit #(
        .MAX_OUT    (MAX_OUT)
    ) u_credit (
        .clk        (clk),
        .rstn       (rstn),
        .inc        (w_accept),
        .dec        (b_hsk),
        .slot_avail (w_slot)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= IDLE;
            busy            <= 1'b0;
            issue_done      <= 1'b0;
            issue_abort     <= 1'b0;
            axi_awvld       <= 1'b0;
            axi_wvld        <= 1'b0;
            axi_awaddr      <= '0;
            axi_wdata       <= '0;
            header_flit_num <= '0;
            data_flit_num   <= '0;
            r_base          <= '0;
            r_total         <= '0;
            r_index         <= '0;
            r_err           <= 1'b0;
        end else begin
            issue_done  <= 1'b0;
            issue_abort <= 1'b0;

            if (w_accept) begin
                axi_awvld  <= 1'b1;
                axi_awaddr <= r_base + w_offset;
                axi_wvld   <= 1'b1;
                axi_wdata  <= flit_data;
                r_index    <= r_index + 1'b1;
            end else begin
                if (axi_awvld && axi_awrdy) axi_awvld <= 1'b0;
                if (axi_wvld && axi_wrdy)   axi_wvld  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        header_flit_num <= hdr_num_in;
                        data_flit_num   <= dat_num_in;
                        r_base          <= base_addr;
                        r_total         <= TOT_W'(hdr_num_in) + TOT_W'(dat_num_in);
                        r_index         <= '0;
                        r_err           <= 1'b0;
                        busy            <= 1'b1;
                        // An empty packet passes one idle ISSUE cycle on its way to DONE.
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_err) r_err <= 1'b1;
                    if (!w_aw_pend && !w_w_pend) begin
                        if (wr_err || r_err) begin
                            r_state     <= ABORT;
                            issue_abort <= 1'b1;
                        end else if (r_index == r_total) begin
                            r_state    <= DONE;
                            issue_done <= 1'b1;
                        end
                    end
                end
                DONE, ABORT: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_aw_w_master_ctl.sv
// ============================================================================
// tb_axi_aw_w_master_ctl : randomized bench with transaction-level model  rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_aw_w_master_ctl;

    localparam int ADDR_W    = 40;
    localparam int DATA_W    = 128;
    localparam int HDR_NUM_W = 8;
    localparam int DAT_NUM_W = 16;
    localparam int MAX_OUT   = 2;
    localparam int STRIDE    = DATA_W / 8;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  start = 1'b0;
    logic [ADDR_W-1:0]     base_addr = '0;
    logic [HDR_NUM_W-1:0]  hdr_num_in = '0;
    logic [DAT_NUM_W-1:0]  dat_num_in = '0;
    logic                  busy, issue_done, issue_abort;
    logic [HDR_NUM_W-1:0]  header_flit_num;
    logic [DAT_NUM_W-1:0]  data_flit_num;
    logic                  flit_vld = 1'b0;
    logic [DATA_W-1:0]     flit_data = '0;
    logic                  flit_rdy;
    logic                  b_hsk = 1'b0;
    logic                  wr_err = 1'b0;
    logic [ADDR_W-1:0]     axi_awaddr;
    logic [7:0]            axi_awlen;
    logic [2:0]            axi_awsize;
    logic [1:0]            axi_awburst;
    logic                  axi_awvld;
    logic                  axi_awrdy = 1'b0;
    logic [DATA_W-1:0]     axi_wdata;
    logic [DATA_W/8-1:0]   axi_wstrb;
    logic                  axi_wlast;
    logic                  axi_wvld;
    logic                  axi_wrdy = 1'b0;

    always #5 clk = ~clk;

    axi_aw_w_master_ctl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HDR_NUM_W(HDR_NUM_W),
        .DAT_NUM_W(DAT_NUM_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .hdr_num_in(hdr_num_in), .dat_num_in(dat_num_in), .busy(busy),
        .issue_done(issue_done), .issue_abort(issue_abort),
        .header_flit_num(header_flit_num), .data_flit_num(data_flit_num),
        .flit_vld(flit_vld), .flit_data(flit_data), .flit_rdy(flit_rdy),
        .b_hsk(b_hsk), .wr_err(wr_err),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvld(axi_awvld), .axi_awrdy(axi_awrdy),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvld(axi_wvld), .axi_wrdy(axi_wrdy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected beats still owed on each channel, plus packet bookkeeping.
    logic [ADDR_W-1:0] aw_q[$];
    logic [DATA_W-1:0] w_q[$];
    logic [ADDR_W-1:0] base_m = '0;
    int  hdr_m = 0, dat_m = 0, total_m = 0, k_m = 0, out_m = 0, acc = 0;
    bit  in_issue = 0, err_seen = 0, due_done = 0, due_abort = 0;

    // Stimulus knobs
    int  p_vld = 100, p_awr = 100, p_wr = 100, p_b = 100;
    int  stall_aw = 0, err_at = -1;
    bit  b_block = 0, b_force = 0, stall_on_err = 0;
    logic [ADDR_W-1:0]    nxt_base = '0;
    logic [HDR_NUM_W-1:0] nxt_hdr = '0;
    logic [DAT_NUM_W-1:0] nxt_dat = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit do_start);
        bit exp_rdy, exp_done, exp_abort, exp_busy, acc_now;
        @(negedge clk);
        exp_done  = due_done;
        exp_abort = due_abort;
        exp_busy  = in_issue || due_done || due_abort;
        due_done  = 0;
        due_abort = 0;

        start = 1'b0;
        if (do_start) begin
            start = 1'b1; base_addr = nxt_base; hdr_num_in = nxt_hdr; dat_num_in = nxt_dat;
        end else if (exp_busy && $urandom_range(7) == 0) begin
            start      = 1'b1;
            base_addr  = ADDR_W'({$urandom, $urandom});
            hdr_num_in = HDR_NUM_W'($urandom_range(255));
            dat_num_in = DAT_NUM_W'($urandom_range(65535));
        end
        flit_vld  = ($urandom_range(99) < p_vld);
        flit_data = {$urandom, $urandom, $urandom, $urandom};
        if (in_issue) wr_err = !err_seen && err_at >= 0 && k_m == err_at;
        else          wr_err = ($urandom_range(9) == 0);
        if (wr_err && in_issue && stall_on_err) stall_aw = 5;
        if (stall_aw > 0) begin
            axi_awrdy = 1'b0;
            stall_aw--;
        end else begin
            axi_awrdy = ($urandom_range(99) < p_awr);
        end
        axi_wrdy = ($urandom_range(99) < p_wr);
        b_hsk = (b_force || (!b_block && $urandom_range(99) < p_b)) && out_m > 0;
        #1;

        exp_rdy = in_issue && k_m < total_m && out_m < MAX_OUT
                && (aw_q.size() == 0 || axi_awrdy) && (w_q.size() == 0 || axi_wrdy)
                && !err_seen && !wr_err;
        chk("flit_rdy", flit_rdy, exp_rdy);
        chk("awvld", axi_awvld, aw_q.size() != 0);
        chk("wvld", axi_wvld, w_q.size() != 0);
        if (aw_q.size() != 0) chk("awaddr", axi_awaddr, aw_q[0]);
        if (w_q.size() != 0)  chk("wdata", axi_wdata, w_q[0]);
        chk("issue_done", issue_done, exp_done);
        chk("issue_abort", issue_abort, exp_abort);
        chk("busy", busy, exp_busy);
        chk("hdr_num", header_flit_num, hdr_m);
        chk("dat_num", data_flit_num, dat_m);

        if (axi_awvld && axi_awrdy && aw_q.size() != 0) void'(aw_q.pop_front());
        if (axi_wvld && axi_wrdy && w_q.size() != 0)    void'(w_q.pop_front());
        acc_now = flit_vld && flit_rdy;
        if (acc_now) begin
            aw_q.push_back(base_m + ADDR_W'(k_m) * ADDR_W'(STRIDE));
            w_q.push_back(flit_data);
            k_m++;
            acc++;
        end
        out_m = out_m + (acc_now ? 1 : 0) - (b_hsk ? 1 : 0);
        if (in_issue && wr_err) err_seen = 1;
        if (in_issue && aw_q.size() == 0 && w_q.size() == 0 && (err_seen || k_m == total_m)) begin
            in_issue = 0;
            if (err_seen) due_abort = 1;
            else          due_done  = 1;
        end
        if (start && !exp_busy) begin
            base_m = base_addr; hdr_m = int'(hdr_num_in); dat_m = int'(dat_num_in);
            total_m = hdr_m + dat_m; k_m = 0; err_seen = 0; in_issue = 1;
        end
    endtask

    task automatic finish_pkt();
        int n;
        n = 0;
        while ((in_issue || due_done || due_abort) && n < 3000) begin
            step(0);
            n++;
        end
        if (n >= 3000) chk("pkt_timeout", 1, 0);
    endtask

    task automatic run_pkt(input logic [ADDR_W-1:0] b, input int h, input int d);
        nxt_base = b; nxt_hdr = HDR_NUM_W'(h); nxt_dat = DAT_NUM_W'(d);
        acc = 0;
        step(1);
        finish_pkt();
    endtask

    task automatic drain();
        int n;
        n = 0;
        p_b = 100; b_block = 0;
        while (out_m > 0 && n < 50) begin
            step(0);
            n++;
        end
        chk("drain", out_m, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rdy", flit_rdy, 0);
        chk("rst_awvld", axi_awvld, 0);
        chk("rst_awaddr", axi_awaddr, 0);
        chk("rst_wdata", axi_wdata, 0);
        chk("rst_hdr", header_flit_num, 0);
        rstn = 1'b1;
        chk("awlen", axi_awlen, 0);
        chk("awsize", axi_awsize, 4);
        chk("awburst", axi_awburst, 2'b01);
        chk("wstrb", axi_wstrb, {16{1'b1}});
        chk("wlast", axi_wlast, 1);

        // Full-rate packet: five beats at 0x1000 stride 0x10
        run_pkt(40'h1000, 2, 3);
        chk("p1_acc", acc, 5);
        chk("p1_hdr", header_flit_num, 2);
        chk("p1_dat", data_flit_num, 3);

        run_pkt(40'h2000, 0, 0);
        chk("empty_acc", acc, 0);

        // Outstanding limit with responses withheld
        drain();
        b_block = 1; acc = 0;
        nxt_base = 40'h3000; nxt_hdr = 0; nxt_dat = 4;
        step(1);
        repeat (8) step(0);
        chk("thr_acc2", acc, 2);
        b_force = 1; step(0); b_force = 0;
        chk("thr_acc_b", acc, 2);
        step(0);
        chk("thr_acc3", acc, 3);
        repeat (4) step(0);
        chk("thr_hold3", acc, 3);
        b_block = 0;
        finish_pkt();

        // AW stalled while W is free
        drain();
        stall_aw = 0; acc = 0;
        nxt_base = 40'h4000; nxt_hdr = 1; nxt_dat = 1;
        step(1);
        stall_aw = 6;
        finish_pkt();
        chk("stall_acc", acc, 2);

        // Write error after the 2nd flit with AW stalled
        drain();
        err_at = 2; stall_on_err = 1;
        run_pkt(40'h5000, 0, 6);
        chk("err_acc", acc, 2);
        chk("err_k_lt_total", k_m < total_m, 1);
        err_at = -1; stall_on_err = 0;

        run_pkt(40'hFF_FFFF_FFF0, 0, 2);
        chk("wrap_acc", acc, 2);

        for (int p = 0; p < 40; p++) begin
            p_vld = 40 + $urandom_range(60);
            p_awr = 40 + $urandom_range(60);
            p_wr  = 40 + $urandom_range(60);
            p_b   = 30 + $urandom_range(70);
            nxt_hdr = HDR_NUM_W'($urandom_range(4));
            nxt_dat = DAT_NUM_W'($urandom_range(8));
            err_at = ($urandom_range(4) == 0) ? $urandom_range(int'(nxt_hdr) + int'(nxt_dat)) : -1;
            stall_on_err = ($urandom_range(1) == 1);
            run_pkt(ADDR_W'({$urandom, $urandom}), int'(nxt_hdr), int'(nxt_dat));
        end
        err_at = -1; stall_on_err = 0;

        // Asynchronous reset in the middle of a packet
        p_vld = 100; p_awr = 100; p_wr = 100; p_b = 0;
        nxt_base = 40'h6000; nxt_hdr = 2; nxt_dat = 5;
        step(1);
        repeat (3) step(0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_awvld", axi_awvld, 0);
        chk("arst_wvld", axi_wvld, 0);
        chk("arst_rdy", flit_rdy, 0);
        chk("arst_hdr", header_flit_num, 0);
        aw_q.delete(); w_q.delete();
        out_m = 0; in_issue = 0; due_done = 0; due_abort = 0; hdr_m = 0; dat_m = 0;
        start = 0; flit_vld = 0; b_hsk = 0; wr_err = 0;
        @(negedge clk);
        rstn = 1'b1;
        p_b = 100;
        run_pkt(40'h7000, 1, 2);
        chk("post_rst_acc", acc, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
